uart_rx_deser: RTL and testbench

- Serial receive front-end of the UART_FIFO user block.
- Synchronises the RX pin, detects and validates the start bit, oversamples 8 data bits LSB-first, and checks the stop bit.
- Presents the received byte, irq, busy and frame-error to the Wishbone UART control block. That block drives rx_finish back to acknowledge each byte or error.
- Fixed format: 8N1, no parity.

---
 rtl/uart_rx_deser.sv | 139 +++++++++++++
 tb/tb_uart_rx_deser.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_deser.sv
// 8N1 UART receive front-end: synchronises the RX line, validates the start bit,
// samples each data bit at mid-bit and reports the byte or a framing error.
module uart_rx_deser #(
   parameter int CLK_DIV = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_rx_pin,
   input  logic       i_rx_finish,
   output logic [7:0] o_rx_data,
   output logic       o_irq,
   output logic       o_rx_busy,
   output logic       o_frame_err
);

   localparam int CW = $clog2(CLK_DIV);
   localparam logic [CW-1:0] HALF_M1 = CW'(CLK_DIV / 2 - 1);
   localparam logic [CW-1:0] FULL_M1 = CW'(CLK_DIV - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, FERR} state_t;

   state_t        state, state_nxt;
   logic          sync1, rxs;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [2:0]    idx, idx_nxt;
   logic [7:0]    shreg, shreg_nxt;
   logic [7:0]    data_nxt;
   logic          irq_nxt, busy_nxt, ferr_nxt;
   logic          ack, ack_nxt;
   logic          good_stop;

   // Two-flop synchroniser; resets to the idle (high) line level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b1;
         rxs   <= 1'b1;
      end else begin
         sync1 <= i_rx_pin;
         rxs   <= sync1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         idx         <= '0;
         shreg       <= '0;
         ack         <= 1'b0;
         o_rx_data   <= '0;
         o_irq       <= 1'b0;
         o_rx_busy   <= 1'b0;
         o_frame_err <= 1'b0;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         idx         <= idx_nxt;
         shreg       <= shreg_nxt;
         ack         <= ack_nxt;
         o_rx_data   <= data_nxt;
         o_irq       <= irq_nxt;
         o_rx_busy   <= busy_nxt;
         o_frame_err <= ferr_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      idx_nxt   = idx;
      shreg_nxt = shreg;
      ack_nxt   = ack;
      data_nxt  = o_rx_data;
      ferr_nxt  = o_frame_err;
      good_stop = 1'b0;

      case (state)
         IDLE: begin
            if (!rxs) begin
               state_nxt = START;
               cnt_nxt   = '0;
            end
         end
         START: begin
            cnt_nxt = cnt + CW'(1);
            // Re-check the line half a bit in; a short glitch reads high here.
            if (cnt == HALF_M1) begin
               cnt_nxt = '0;
               if (rxs) begin
                  state_nxt = IDLE;
               end else begin
                  state_nxt = DATA;
                  idx_nxt   = '0;
               end
            end
         end
         DATA: begin
            cnt_nxt = cnt + CW'(1);
            if (cnt == FULL_M1) begin
               cnt_nxt        = '0;
               shreg_nxt[idx] = rxs;
               idx_nxt        = idx + 3'd1;
               if (idx == 3'd7) state_nxt = STOP;
            end
         end
         STOP: begin
            cnt_nxt = cnt + CW'(1);
            if (cnt == FULL_M1) begin
               cnt_nxt = '0;
               if (rxs) begin
                  state_nxt = IDLE;
                  data_nxt  = shreg;
                  good_stop = 1'b1;
               end else begin
                  state_nxt = FERR;
                  ferr_nxt  = 1'b1;
               end
            end
         end
         FERR: begin
            ack_nxt = ack | i_rx_finish;
            // Leave only once acknowledged and the line is back to idle (no break).
            if ((ack || i_rx_finish) && rxs) begin
               state_nxt = IDLE;
               ferr_nxt  = 1'b0;
               ack_nxt   = 1'b0;
            end
         end
         default: state_nxt = IDLE;
      endcase

      irq_nxt = o_irq;
      if (i_rx_finish && (state != FERR)) irq_nxt = 1'b0;
      if (good_stop) irq_nxt = 1'b1;

      busy_nxt = (state_nxt != IDLE);
   end

endmodule

// File: tb/tb_uart_rx_deser.sv
// Directed bench for uart_rx_deser at 16 clocks per bit: good frames, glitch,
// framing error with break, back-to-back frames, ack/set collision and mid-frame reset.
`timescale 1ns/1ps
module tb_uart_rx_deser;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx_pin = 1'b1;
   logic       rx_finish = 1'b0;
   logic [7:0] rx_data;
   logic       irq, rx_busy, frame_err;

   int n_tests = 0;
   int n_fail  = 0;

   uart_rx_deser #(.CLK_DIV(16)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_rx_pin    (rx_pin),
      .i_rx_finish (rx_finish),
      .o_rx_data   (rx_data),
      .o_irq       (irq),
      .o_rx_busy   (rx_busy),
      .o_frame_err (frame_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Drives one 160-cycle frame; iteration i samples outputs after i clock edges
   // counted from the start-bit falling edge.
   task automatic send_frame(input logic [7:0] b, input logic stop_val, input int fin_at,
                             output int irq_rise, output int busy_rise, output logic busy_mid);
      logic [9:0] bits;
      logic [3:0] bi;
      logic       prev_irq;
      bits      = {stop_val, b, 1'b0};
      irq_rise  = -1;
      busy_rise = -1;
      busy_mid  = 1'b0;
      prev_irq  = 1'b0;
      for (int i = 0; i < 160; i++) begin
         @(negedge clk);
         if (i == 0) begin
            prev_irq = irq;
         end else begin
            if (irq && !prev_irq && irq_rise < 0) irq_rise = i;
            prev_irq = irq;
            if (rx_busy && busy_rise < 0) busy_rise = i;
         end
         if (i == 80) busy_mid = rx_busy;
         bi        = 4'(i / 16);
         rx_pin    = bits[bi];
         rx_finish = (i == fin_at);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_finish();
      @(negedge clk);
      rx_finish = 1'b1;
      @(negedge clk);
      rx_finish = 1'b0;
   endtask

   initial begin
      int   rise, brise;
      logic bmid, busy_seen;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_data", rx_data, 8'h00);
      chk("rst_irq", irq, 1'b0);
      chk("rst_busy", rx_busy, 1'b0);
      chk("rst_ferr", frame_err, 1'b0);
      rst_n = 1'b1;
      idle(3);

      // Good frame 0xA5
      send_frame(8'hA5, 1'b1, -1, rise, brise, bmid);
      chk("a5_busy_rise", (brise >= 1 && brise <= 3), 1'b1);
      chk("a5_irq_latency", (rise >= 153 && rise <= 157), 1'b1);
      chk("a5_data", rx_data, 8'hA5);
      chk("a5_irq", irq, 1'b1);
      chk("a5_ferr", frame_err, 1'b0);
      pulse_finish();
      chk("a5_irq_clear", irq, 1'b0);
      idle(4);

      // 5-cycle glitch
      busy_seen = 1'b0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (i > 0 && rx_busy) busy_seen = 1'b1;
         if (i == 12) chk("glitch_busy_idle", rx_busy, 1'b0);
         rx_pin = (i < 5) ? 1'b0 : 1'b1;
      end
      chk("glitch_busy_seen", busy_seen, 1'b1);
      chk("glitch_irq", irq, 1'b0);
      chk("glitch_ferr", frame_err, 1'b0);
      chk("glitch_data", rx_data, 8'hA5);

      // 0x3C with a low stop bit, line held low (break) then released
      send_frame(8'h3C, 1'b0, -1, rise, brise, bmid);
      chk("ferr_set", frame_err, 1'b1);
      chk("ferr_busy", rx_busy, 1'b1);
      chk("ferr_irq", irq, 1'b0);
      chk("ferr_data", rx_data, 8'hA5);
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         rx_finish = (i == 0);
      end
      chk("break_ferr_held", frame_err, 1'b1);
      chk("break_busy_held", rx_busy, 1'b1);
      @(negedge clk);
      rx_pin    = 1'b1;
      rx_finish = 1'b0;
      idle(5);
      chk("ferr_cleared", frame_err, 1'b0);
      chk("ferr_busy_cleared", rx_busy, 1'b0);

      send_frame(8'h81, 1'b1, -1, rise, brise, bmid);
      chk("x81_data", rx_data, 8'h81);
      chk("x81_irq", irq, 1'b1);
      chk("x81_ferr", frame_err, 1'b0);
      pulse_finish();
      chk("x81_irq_clear", irq, 1'b0);

      // Back-to-back 0x11, 0x22 without acknowledge
      send_frame(8'h11, 1'b1, -1, rise, brise, bmid);
      chk("b2b_first_data", rx_data, 8'h11);
      chk("b2b_first_irq", irq, 1'b1);
      send_frame(8'h22, 1'b1, -1, rise, brise, bmid);
      chk("b2b_busy_mid", bmid, 1'b1);
      chk("b2b_irq_no_drop", rise, 32'hFFFF_FFFF);
      chk("b2b_irq", irq, 1'b1);
      chk("b2b_data", rx_data, 8'h22);
      pulse_finish();
      chk("b2b_irq_clear", irq, 1'b0);

      // Acknowledge lands on the same edge that sets irq
      send_frame(8'h6E, 1'b1, 154, rise, brise, bmid);
      chk("setwins_irq", irq, 1'b1);
      chk("setwins_data", rx_data, 8'h6E);

      // Reset in the middle of the data bits of 0xFF
      for (int i = 0; i < 56; i++) begin
         @(negedge clk);
         rx_pin = (i < 16) ? 1'b0 : 1'b1;
      end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_data", rx_data, 8'h00);
      chk("midrst_irq", irq, 1'b0);
      chk("midrst_busy", rx_busy, 1'b0);
      chk("midrst_ferr", frame_err, 1'b0);
      @(negedge clk);
      rx_pin = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      idle(3);
      chk("postrst_busy", rx_busy, 1'b0);
      send_frame(8'h5A, 1'b1, -1, rise, brise, bmid);
      chk("x5a_data", rx_data, 8'h5A);
      chk("x5a_irq", irq, 1'b1);
      chk("x5a_ferr", frame_err, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
